// File: rtl/axi_master_arbiter_pkg.sv
// Shared types and widths for the multi-requester AXI arbiter.
package axi_master_arbiter_pkg;

  localparam int unsigned AxiLenW  = 8;
  localparam int unsigned AxiAddrW = 32;

  typedef enum logic [1:0] {
    StArbitrate,
    StIssueAddress,
    StActiveBurst,
    StWaitResponse
  } burst_state_t;

endpackage

// File: rtl/axi4_interface.sv
// Minimal AXI4 channel bundle used for the arbiter's single downstream port.
interface axi4_interface #(
  parameter int unsigned DATA_WIDTH = 32
);
  import axi_master_arbiter_pkg::*;

  logic                  awvalid;
  logic                  awready;
  logic [AxiAddrW-1:0]   awaddr;
  logic [AxiLenW-1:0]    awlen;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic                  arvalid;
  logic                  arready;
  logic [AxiAddrW-1:0]   araddr;
  logic [AxiLenW-1:0]    arlen;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready, arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready, arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts just after the previous winner and wraps.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((32'(i_last_grant) + i) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Multiplexes NUM_MASTERS AXI requesters onto one downstream port with
// independent round-robin write and read channel controllers.
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_MASTERS-1:0]            m_awvalid,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  input  logic [NUM_MASTERS-1:0]            m_wlast,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  input  logic [NUM_MASTERS*AxiAddrW-1:0]   m_awaddr,
  input  logic [NUM_MASTERS*AxiAddrW-1:0]   m_araddr,
  input  logic [NUM_MASTERS*AxiLenW-1:0]    m_awlen,
  input  logic [NUM_MASTERS*AxiLenW-1:0]    m_arlen,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            s_awready,
  output logic [NUM_MASTERS-1:0]            s_wready,
  output logic [NUM_MASTERS-1:0]            s_bvalid,
  output logic [NUM_MASTERS-1:0]            s_arready,
  output logic [NUM_MASTERS-1:0]            s_rvalid,
  output logic [DATA_WIDTH-1:0]             s_rdata,
  axi4_interface.master                     axi_bus_out
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

  burst_state_t        r_wr_state, r_rd_state;
  logic [IdxW-1:0]     r_wr_idx, r_wr_last, r_rd_idx, r_rd_last;
  logic [AxiAddrW-1:0] r_wr_addr, r_rd_addr;
  logic [AxiLenW-1:0]  r_wr_len, r_wr_cnt, r_rd_len, r_rd_cnt;

  logic [NUM_MASTERS-1:0] w_aw_gnt, w_ar_gnt;
  logic [IdxW-1:0]        w_aw_idx, w_ar_idx;
  logic                   w_w_hs, w_r_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IdxW)
  ) u_aw_arb (
    .i_req        (m_awvalid),
    .i_last_grant (r_wr_last),
    .o_grant      (w_aw_gnt),
    .o_idx        (w_aw_idx)
  );

  rr_arbiter #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IdxW)
  ) u_ar_arb (
    .i_req        (m_arvalid),
    .i_last_grant (r_rd_last),
    .o_grant      (w_ar_gnt),
    .o_idx        (w_ar_idx)
  );

  assign w_w_hs = (r_wr_state == StActiveBurst) && m_wvalid[r_wr_idx] && axi_bus_out.wready;
  assign w_r_hs = (r_rd_state == StActiveBurst) && axi_bus_out.rvalid && m_rready[r_rd_idx];

  // Beat counter alone ends a burst; requester wlast is passed through but never trusted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_state <= StArbitrate;
      r_wr_idx   <= '0;
      r_wr_last  <= IdxW'(NUM_MASTERS - 1);
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_wr_cnt   <= '0;
    end else begin
      unique case (r_wr_state)
        StArbitrate: begin
          if (|w_aw_gnt) begin
            r_wr_idx   <= w_aw_idx;
            r_wr_last  <= w_aw_idx;
            r_wr_addr  <= m_awaddr[AxiAddrW*w_aw_idx +: AxiAddrW];
            r_wr_len   <= m_awlen[AxiLenW*w_aw_idx +: AxiLenW];
            r_wr_cnt   <= m_awlen[AxiLenW*w_aw_idx +: AxiLenW];
            r_wr_state <= StIssueAddress;
          end
        end
        StIssueAddress: if (axi_bus_out.awready) r_wr_state <= StActiveBurst;
        StActiveBurst: begin
          if (w_w_hs) begin
            if (r_wr_cnt == '0) r_wr_state <= StWaitResponse;
            else                r_wr_cnt   <= r_wr_cnt - AxiLenW'(1);
          end
        end
        StWaitResponse: if (axi_bus_out.bvalid && m_bready[r_wr_idx]) r_wr_state <= StArbitrate;
        default: r_wr_state <= StArbitrate;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_state <= StArbitrate;
      r_rd_idx   <= '0;
      r_rd_last  <= IdxW'(NUM_MASTERS - 1);
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_rd_cnt   <= '0;
    end else begin
      unique case (r_rd_state)
        StArbitrate: begin
          if (|w_ar_gnt) begin
            r_rd_idx   <= w_ar_idx;
            r_rd_last  <= w_ar_idx;
            r_rd_addr  <= m_araddr[AxiAddrW*w_ar_idx +: AxiAddrW];
            r_rd_len   <= m_arlen[AxiLenW*w_ar_idx +: AxiLenW];
            r_rd_cnt   <= m_arlen[AxiLenW*w_ar_idx +: AxiLenW];
            r_rd_state <= StIssueAddress;
          end
        end
        StIssueAddress: if (axi_bus_out.arready) r_rd_state <= StActiveBurst;
        StActiveBurst: begin
          if (w_r_hs) begin
            if (r_rd_cnt == '0) r_rd_state <= StArbitrate;
            else                r_rd_cnt   <= r_rd_cnt - AxiLenW'(1);
          end
        end
        default: r_rd_state <= StArbitrate;
      endcase
    end
  end

  always_comb begin
    s_awready           = '0;
    s_wready            = '0;
    s_bvalid            = '0;
    axi_bus_out.awvalid = 1'b0;
    axi_bus_out.awaddr  = '0;
    axi_bus_out.awlen   = '0;
    axi_bus_out.wvalid  = 1'b0;
    axi_bus_out.wdata   = '0;
    axi_bus_out.wlast   = 1'b0;
    axi_bus_out.bready  = 1'b0;
    unique case (r_wr_state)
      StIssueAddress: begin
        axi_bus_out.awvalid = 1'b1;
        axi_bus_out.awaddr  = r_wr_addr;
        axi_bus_out.awlen   = r_wr_len;
        s_awready[r_wr_idx] = axi_bus_out.awready;
      end
      StActiveBurst: begin
        axi_bus_out.wvalid = m_wvalid[r_wr_idx];
        axi_bus_out.wdata  = m_wdata[DATA_WIDTH*r_wr_idx +: DATA_WIDTH];
        axi_bus_out.wlast  = m_wlast[r_wr_idx];
        s_wready[r_wr_idx] = axi_bus_out.wready;
      end
      StWaitResponse: begin
        axi_bus_out.bready = m_bready[r_wr_idx];
        s_bvalid[r_wr_idx] = axi_bus_out.bvalid;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_arready           = '0;
    s_rvalid            = '0;
    s_rdata             = '0;
    axi_bus_out.arvalid = 1'b0;
    axi_bus_out.araddr  = '0;
    axi_bus_out.arlen   = '0;
    axi_bus_out.rready  = 1'b0;
    unique case (r_rd_state)
      StIssueAddress: begin
        axi_bus_out.arvalid = 1'b1;
        axi_bus_out.araddr  = r_rd_addr;
        axi_bus_out.arlen   = r_rd_len;
        s_arready[r_rd_idx] = axi_bus_out.arready;
      end
      StActiveBurst: begin
        axi_bus_out.rready = m_rready[r_rd_idx];
        s_rvalid[r_rd_idx] = axi_bus_out.rvalid;
        s_rdata            = axi_bus_out.rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: reset, single write, fairness,
// concurrent channels, max burst, mid-burst reset and address backpressure.
module tb_axi_master_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [N-1:0]      m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
  logic [N*32-1:0]   m_awaddr, m_araddr;
  logic [N*8-1:0]    m_awlen, m_arlen;
  logic [N*DW-1:0]   m_wdata;
  logic [N-1:0]      s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [DW-1:0]     s_rdata;

  axi4_interface #(.DATA_WIDTH(DW)) bus ();

  axi_master_arbiter #(
    .NUM_MASTERS (N),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m_awvalid   (m_awvalid),
    .m_wvalid    (m_wvalid),
    .m_wlast     (m_wlast),
    .m_bready    (m_bready),
    .m_arvalid   (m_arvalid),
    .m_rready    (m_rready),
    .m_awaddr    (m_awaddr),
    .m_araddr    (m_araddr),
    .m_awlen     (m_awlen),
    .m_arlen     (m_arlen),
    .m_wdata     (m_wdata),
    .s_awready   (s_awready),
    .s_wready    (s_wready),
    .s_bvalid    (s_bvalid),
    .s_arready   (s_arready),
    .s_rvalid    (s_rvalid),
    .s_rdata     (s_rdata),
    .axi_bus_out (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
    m_arvalid = '0; m_rready = '0;
    m_awaddr = '0; m_araddr = '0; m_awlen = '0; m_arlen = '0; m_wdata = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== 20'h0) begin
      bad++;
      $display("FAIL reset_s_out got=%h want=0", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid});
    end
    total++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_bus_valid got=%b want=00000",
               {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
    end
    total++;
    if ({bus.awaddr, bus.araddr, bus.awlen, bus.arlen} !== 80'h0) begin
      bad++;
      $display("FAIL reset_bus_addr got=%h want=0", {bus.awaddr, bus.araddr, bus.awlen, bus.arlen});
    end
    // Downstream activity with no requests must not leak to any requester.
    bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1;
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678;
    #1;
    total++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata} !== 52'h0) begin
      bad++;
      $display("FAIL idle_no_leak got=%h want=0",
               {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata});
    end
    idle_inputs();
  endtask

  task automatic test_single_write();
    logic [31:0] exp_d;
    apply_reset();
    m_wdata = {4{32'hBAD0_BAD0}};
    m_awvalid[2] = 1'b1;
    m_awaddr[64 +: 32] = 32'h0000_1000;
    m_awlen[16 +: 8] = 8'd3;
    #1;
    total++;
    if (bus.awvalid !== 1'b0) begin
      bad++; $display("FAIL wr_awvalid_early got=%b want=0", bus.awvalid);
    end
    tick();
    total++;
    if ({bus.awvalid, bus.awaddr, bus.awlen} !== {1'b1, 32'h0000_1000, 8'd3}) begin
      bad++;
      $display("FAIL wr_issue got=%b/%h/%0d want=1/00001000/3", bus.awvalid, bus.awaddr, bus.awlen);
    end
    bus.awready = 1'b1;
    #1;
    total++;
    if (s_awready !== 4'b0100) begin
      bad++; $display("FAIL wr_s_awready got=%b want=0100", s_awready);
    end
    tick();
    m_awvalid = '0; bus.awready = 1'b0; bus.wready = 1'b1; m_wvalid[2] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp_d = 32'hC0DE_0000 + 32'(b);
      m_wdata[64 +: 32] = exp_d;
      m_wlast[2] = (b == 3);
      #1;
      total++;
      if ({bus.wvalid, bus.wdata, bus.wlast} !== {1'b1, exp_d, (b == 3)}) begin
        bad++;
        $display("FAIL wr_beat%0d got=%b/%h/%b want=1/%h/%b", b, bus.wvalid, bus.wdata, bus.wlast,
                 exp_d, (b == 3));
      end
      total++;
      if (s_wready !== 4'b0100) begin
        bad++; $display("FAIL wr_s_wready%0d got=%b want=0100", b, s_wready);
      end
      tick();
    end
    m_wlast = '0;
    m_bready[2] = 1'b1;
    #1;
    total++;
    if ({bus.wvalid, s_wready, bus.bready, s_bvalid} !== {1'b0, 4'b0000, 1'b1, 4'b0000}) begin
      bad++;
      $display("FAIL wr_wait_resp got=%b/%b/%b/%b want=0/0000/1/0000", bus.wvalid, s_wready,
               bus.bready, s_bvalid);
    end
    bus.bvalid = 1'b1;
    #1;
    total++;
    if (s_bvalid !== 4'b0100) begin
      bad++; $display("FAIL wr_s_bvalid got=%b want=0100", s_bvalid);
    end
    tick();
    #1;
    total++;
    if ({s_bvalid, bus.bready, bus.awvalid, bus.wvalid} !== 7'b0) begin
      bad++;
      $display("FAIL wr_back_idle got=%b/%b/%b/%b want=0000/0/0/0", s_bvalid, bus.bready,
               bus.awvalid, bus.wvalid);
    end
    idle_inputs();
  endtask

  task automatic test_fairness();
    int unsigned order [6] = '{0, 1, 3, 0, 1, 3};
    logic [3:0]  exp_g;
    logic [31:0] exp_a;
    int          k;
    apply_reset();
    m_arvalid = 4'b1011;
    m_araddr  = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    m_rready  = '1;
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h5A5A_0000;
    for (int t = 0; t < 6; t++) begin
      exp_g = 4'b0001 << order[t];
      exp_a = 32'h0000_1000 * (order[t] + 1);
      #1;
      k = 0;
      while (bus.arvalid !== 1'b1 && k < 6) begin
        tick();
        k++;
      end
      total++;
      if ({bus.arvalid, s_arready, bus.araddr} !== {1'b1, exp_g, exp_a}) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b/%b/%h want=1/%b/%h", t, bus.arvalid, s_arready,
                 bus.araddr, exp_g, exp_a);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_concurrency();
    logic [31:0] bb;
    apply_reset();
    m_awvalid[1] = 1'b1; m_awaddr[32 +: 32] = 32'h0000_8000; m_awlen[8 +: 8] = 8'd7;
    m_arvalid[0] = 1'b1; m_araddr[0 +: 32]  = 32'h0000_9000; m_arlen[0 +: 8] = 8'd7;
    tick();
    bus.awready = 1'b1; bus.arready = 1'b1;
    #1;
    total++;
    if ({bus.awvalid, bus.arvalid, s_awready, s_arready, bus.awlen, bus.arlen} !==
        {2'b11, 4'b0010, 4'b0001, 8'd7, 8'd7}) begin
      bad++;
      $display("FAIL cc_issue got=%b%b/%b/%b/%0d/%0d want=11/0010/0001/7/7", bus.awvalid,
               bus.arvalid, s_awready, s_arready, bus.awlen, bus.arlen);
    end
    tick();
    m_awvalid = '0; m_arvalid = '0; bus.awready = 1'b0; bus.arready = 1'b0;
    m_wvalid = 4'b1111; m_rready = 4'b1111; bus.wready = 1'b1; bus.rvalid = 1'b1;
    for (int b = 0; b < 8; b++) begin
      bb = 32'(b);
      m_wdata = {32'hA003_0000 + bb, 32'hA002_0000 + bb, 32'hA001_0000 + bb, 32'hA000_0000 + bb};
      bus.rdata = 32'hB000_0000 + bb;
      m_wlast = (b == 7) ? 4'b1111 : 4'b0000;
      #1;
      total++;
      if (bus.wdata !== 32'hA001_0000 + bb) begin
        bad++; $display("FAIL cc_wdata%0d got=%h want=%h", b, bus.wdata, 32'hA001_0000 + bb);
      end
      total++;
      if ({s_wready, s_rvalid, bus.rready} !== {4'b0010, 4'b0001, 1'b1}) begin
        bad++;
        $display("FAIL cc_route%0d got=%b/%b/%b want=0010/0001/1", b, s_wready, s_rvalid,
                 bus.rready);
      end
      total++;
      if (s_rdata !== 32'hB000_0000 + bb) begin
        bad++; $display("FAIL cc_rdata%0d got=%h want=%h", b, s_rdata, 32'hB000_0000 + bb);
      end
      tick();
    end
    #1;
    total++;
    if ({s_rvalid, bus.rready, bus.wvalid, s_wready} !== 10'b0) begin
      bad++;
      $display("FAIL cc_burst_end got=%b/%b/%b/%b want=0000/0/0/0000", s_rvalid, bus.rready,
               bus.wvalid, s_wready);
    end
    m_bready = 4'b1111; bus.bvalid = 1'b1;
    #1;
    total++;
    if ({s_bvalid, bus.bready} !== {4'b0010, 1'b1}) begin
      bad++; $display("FAIL cc_bresp got=%b/%b want=0010/1", s_bvalid, bus.bready);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_max_burst();
    int beats;
    int cycles;
    int lost;
    apply_reset();
    m_arvalid[2] = 1'b1; m_araddr[64 +: 32] = 32'h0000_F000; m_arlen[16 +: 8] = 8'd255;
    tick();
    bus.arready = 1'b1;
    #1;
    total++;
    if ({bus.arlen, s_arready} !== {8'd255, 4'b0100}) begin
      bad++; $display("FAIL mb_issue got=%0d/%b want=255/0100", bus.arlen, s_arready);
    end
    tick();
    m_arvalid = '0; bus.arready = 1'b0; m_rready[2] = 1'b1;
    beats = 0; cycles = 0; lost = 0;
    while (beats < 256 && cycles < 3000) begin
      bus.rvalid = 1'($urandom_range(0, 1));
      bus.rdata  = 32'(beats);
      #1;
      if (bus.rvalid) begin
        if (s_rvalid !== 4'b0100 || bus.rready !== 1'b1 || s_rdata !== 32'(beats)) lost++;
        beats++;
      end
      tick();
      cycles++;
    end
    total++;
    if (beats !== 256) begin
      bad++; $display("FAIL mb_beats got=%0d want=256", beats);
    end
    total++;
    if (lost !== 0) begin
      bad++; $display("FAIL mb_lost_beats got=%0d want=0", lost);
    end
    bus.rvalid = 1'b1;
    #1;
    total++;
    if ({s_rvalid, bus.rready, bus.arvalid} !== 6'b0) begin
      bad++;
      $display("FAIL mb_end got=%b/%b/%b want=0000/0/0", s_rvalid, bus.rready, bus.arvalid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    m_awvalid[1] = 1'b1; m_awaddr[32 +: 32] = 32'h0000_7000; m_awlen[8 +: 8] = 8'd3;
    bus.awready = 1'b1;
    tick();
    tick();
    m_awvalid = '0; bus.awready = 1'b0; bus.wready = 1'b1;
    m_wvalid[1] = 1'b1; m_wdata[32 +: 32] = 32'h7777_0000;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    total++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
      bad++;
      $display("FAIL rst_mid_valid got=%b want=00000",
               {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
    end
    total++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata} !== 52'h0) begin
      bad++;
      $display("FAIL rst_mid_s_out got=%h want=0",
               {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata});
    end
    total++;
    if ({bus.wdata, bus.awaddr, bus.awlen} !== 72'h0) begin
      bad++; $display("FAIL rst_mid_data got=%h want=0", {bus.wdata, bus.awaddr, bus.awlen});
    end
    reset_n = 1'b1;
    tick();
    total++;
    if (bus.wvalid !== 1'b0) begin
      bad++; $display("FAIL rst_no_resume got=%b want=0", bus.wvalid);
    end
    m_wvalid = '0;
    m_awvalid = 4'b0101;
    m_awaddr[0 +: 32]  = 32'h0000_0A00;
    m_awaddr[64 +: 32] = 32'h0000_0C00;
    bus.awready = 1'b1;
    tick();
    total++;
    if ({s_awready, bus.awaddr} !== {4'b0001, 32'h0000_0A00}) begin
      bad++; $display("FAIL rst_next_grant got=%b/%h want=0001/00000a00", s_awready, bus.awaddr);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    apply_reset();
    m_awvalid = 4'b0011;
    m_awaddr[0 +: 32]  = 32'h0000_2000; m_awlen[0 +: 8] = 8'd1;
    m_awaddr[32 +: 32] = 32'h0000_3000; m_awlen[8 +: 8] = 8'd5;
    tick();
    // Live inputs move; the issued address must come from the latched copy.
    m_awaddr[0 +: 32] = 32'hFFFF_0000; m_awlen[0 +: 8] = 8'd9;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if ({bus.awvalid, bus.awaddr, bus.awlen, s_awready, bus.wvalid} !==
          {1'b1, 32'h0000_2000, 8'd1, 4'b0000, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b/%h/%0d/%b/%b want=1/00002000/1/0000/0", c, bus.awvalid,
                 bus.awaddr, bus.awlen, s_awready, bus.wvalid);
      end
      tick();
    end
    bus.awready = 1'b1;
    #1;
    total++;
    if (s_awready !== 4'b0001) begin
      bad++; $display("FAIL bp_release got=%b want=0001", s_awready);
    end
    tick();
    #1;
    total++;
    if ({bus.awvalid, s_awready} !== 5'b0) begin
      bad++; $display("FAIL bp_no_other_grant got=%b/%b want=0/0000", bus.awvalid, s_awready);
    end
    idle_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_fairness();
    test_concurrency();
    test_max_burst();
    test_reset_mid_burst();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
